shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential 4x4 unsigned multiplier built around the team's existing 4-bit ripple-carry adder. It sits directly downstream of that adder: it consumes the adder's sum and carry-out each cycle to form a running partial product. The result is an 8-bit product after four add-and-shift steps. It provides a start/done handshake so a controller can issue operands one multiplication at a time.

## Interface
- Parameters: none. Operand width is fixed at 4 bits by the reused adder, and the product width is fixed at 8 bits.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  request; sampled only in IDLE
- a  input  4  multiplicand, captured when start is accepted
- b  input  4  multiplier, captured when start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- product  output  8  registered result; updated on entry to DONE and held until the next completion

## Operation
- Internal registers:
  - M[3:0] holds the multiplicand.
  - A[3:0] holds the upper partial product.
  - Q[3:0] holds the multiplier, shifting out toward the product.
  - cnt[1:0] is the step counter.
  - state[1:0] is the FSM state.
- Adder hookup:
  - x = A.
  - y = Q[0] ? M : 4'b0000.
  - The adder's sum and carry-out are s[3:0] and c.
- FSM transitions:
  - IDLE to RUN when start=1. On that edge: M<=a, Q<=b, A<=0, cnt<=0.
  - RUN: each edge performs {A,Q} <= {c, s, Q[3:1]} and cnt<=cnt+1. When cnt==3, go to DONE and load product <= {c, s, Q[3:1]}, which is the final shifted value.
  - DONE: done=1. The next edge always returns to IDLE.
- start is ignored in RUN and DONE. Operands changing while busy have no effect.
- Arithmetic is unsigned. The carry-out is shifted into A[3], so no overflow is possible: 15x15=225 fits in 8 bits.
- Reset, sampled on any edge with rst_n=0: state=IDLE, M=A=Q=0, cnt=0, product=8'h00, busy=0, done=0. An in-flight operation is abandoned and no done is issued for it.
- A start high in the same cycle as rst_n=0 is ignored, because reset has priority.

## Timing
- Reset values of all outputs: busy=0, done=0, product=0.
- Cycle numbering, with cycle 0 the cycle in which start=1 is sampled in IDLE:
  - Cycles 1-4: RUN, busy=1.
  - Cycle 5: DONE. done=1 and product holds the new value from cycle 5 onward.
  - Cycle 6: IDLE. start is sampled again here.
- Minimum issue interval is 6 cycles, so start held high continuously yields one done every 6 cycles.
- The adder path is combinational between A/M/Q and the A/Q registers. It is one 4-bit ripple within one cycle, with no extra pipeline stage.
- done is never high for 2 consecutive cycles. busy and done are never high together.

## Structure
- Shared package/header mult_defs holds:
  - WIDTH=4 and STEPS=4.
  - State encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The code 2'b11 is unused and decodes to IDLE.
- There is one sub-module instance: ripple_carry_adder, used unmodified with its x, y, s, c ports. Its carry-in is tied to 0 inside that module.
- All sequential logic lives in shift_add_multiplier: the FSM, counter, operand registers and product register.

## Test plan
- Reset, then a=0, b=0, start for 1 cycle. Required: busy high in cycles 1-4, done pulse in cycle 5, product=8'h00.
- a=15, b=15. Required: product=8'hE1 (225) in cycle 5, and product still 8'hE1 in cycles 6-20 with start low.
- a=13, b=11. Required: product=8'h8F (143). Then a=4'h9, b=4'h1 is applied during RUN of this operation with start pulsed. Required: that start is ignored, and the first done shows 8'h8F.
- start held high, operands changed to (3,5), (7,9), (15,1) at each acceptance. Required: done in cycles 5, 11 and 17, with product 8'h0F, 8'h3F and 8'h0F respectively.
- Start a=12, b=12, then assert rst_n=0 for one cycle in cycle 3. Required on the following cycle: busy=0, done=0, product=8'h00, and no done for the aborted operation. A new operation a=6, b=7 then yields 8'h2A (42).
- Exhaustive sweep of all 256 (a,b) pairs. Required: each result matches a*b, and done width is exactly 1 cycle each time.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared widths and FSM encodings for the sequential shift-add multiplier.
package mult_defs;
  localparam int WIDTH = 4;
  localparam int STEPS = 4;
  localparam int PW    = 2 * WIDTH;

  // 2'b11 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder; carry-in is tied low internally.
module ripple_carry_adder
  import mult_defs::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  logic [WIDTH:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]    = x[i] ^ y[i] ^ cy[i];
    assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
  end

  assign c = cy[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// 4x4 unsigned multiplier: one conditional add and right shift of {A,Q} per
// cycle through the reused ripple adder, with a start/busy/done handshake.
module shift_add_multiplier
  import mult_defs::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [PW-1:0]   product
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_reg, a_reg, q_reg;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] add_y, sum;
  logic             cout;
  logic [PW-1:0]    shifted;
  logic             last_step;

  assign add_y     = q_reg[0] ? m_reg : '0;
  assign shifted   = {cout, sum, q_reg[WIDTH-1:1]};
  assign last_step = (cnt == 2'(STEPS - 1));

  ripple_carry_adder u_add (
    .x (a_reg),
    .y (add_y),
    .s (sum),
    .c (cout)
  );

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last_step ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = start ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        RUN: begin
          {a_reg, q_reg} <= shifted;
          cnt            <= cnt + 2'd1;
          if (last_step) product <= shifted;
        end
        DONE: ;
        default: begin
          // Undefined code 2'b11 behaves exactly like IDLE.
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products are queued on
// accepted starts and checked whenever done pulses.
module tb_shift_add_multiplier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done;
  logic [7:0] product;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic done_d = 1'b0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(product), 32'hFFFF_FFFF);
      else chk("sb_product", 32'(product), 32'(sb.pop_front()));
      chk("done_width", 32'(done_d), 32'd0);
      chk("busy_with_done", 32'(busy), 32'd0);
    end
    done_d <= done;
  end

  // Issue one operation and check the cycle-exact handshake through cycle 6.
  task automatic op_timed(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] exp;
    exp = 8'(x) * 8'(y);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("c5_done", 32'(done), 32'd1);
    chk("c5_product", 32'(product), 32'(exp));
    @(negedge clk);
    chk("c6_idle", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, with start high to confirm reset priority.
    start = 1'b1; a = 4'd5; b = 4'd5;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    op_timed(4'd0, 4'd0);

    op_timed(4'd15, 4'd15);
    for (int i = 7; i <= 20; i++) begin
      @(negedge clk);
      chk("e1_hold", 32'(product), 32'hE1);
    end

    // 13x11 with a stray start pulse during RUN that must be ignored.
    @(posedge clk); #1;
    a = 4'd13; b = 4'd11; start = 1'b1;
    sb.push_back(8'h8F);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    a = 4'h9; b = 4'h1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 3; k <= 5; k++) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_product", 32'(product), 32'h8F);
    repeat (12) @(negedge clk);
    chk("ign_no_done", 32'(done), 32'd0);

    // start held high: back-to-back issue every 6 cycles.
    @(posedge clk); #1;
    a = 4'd3; b = 4'd5; start = 1'b1;
    sb.push_back(8'h0F);
    @(posedge clk); #1;
    a = 4'd7; b = 4'd9;
    sb.push_back(8'h3F);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("bb_done", 32'(done), 32'(k == 5 || k == 11 || k == 17));
      if (k == 5)  chk("bb_p0", 32'(product), 32'h0F);
      if (k == 11) chk("bb_p1", 32'(product), 32'h3F);
      if (k == 17) chk("bb_p2", 32'(product), 32'h0F);
      if (k == 7) begin
        a = 4'd15; b = 4'd1;
        sb.push_back(8'h0F);
      end
      if (k == 13) start = 1'b0;
    end
    @(negedge clk);
    chk("bb_idle", 32'({busy, done}), 32'd0);

    // Abort an in-flight 12x12 with reset in cycle 3.
    @(posedge clk); #1;
    a = 4'd12; b = 4'd12; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_product_hold", 32'(product), 32'd0);
    op_timed(4'd6, 4'd7);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op_timed(4'(x), 4'(y));

    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
